// File: rtl/sweep_ctrl.sv
// Frequency sweep controller. It steps a frequency word from start_freq
// toward stop_freq. Each point is held for dwell+1 enabled cycles. The
// sweep runs as a single ramp, a sawtooth or a triangle. Each frequency
// write raises the load strobe for the sine generator.
module sweep_ctrl #(
    parameter int FREQ_WL  = 8,
    parameter int DWELL_WL = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                start,
    input  logic                stop,
    input  logic [FREQ_WL-1:0]  start_freq,
    input  logic [FREQ_WL-1:0]  stop_freq,
    input  logic [FREQ_WL-1:0]  step,
    input  logic [DWELL_WL-1:0] dwell,
    input  logic [1:0]          mode,
    output logic [FREQ_WL-1:0]  freq,
    output logic                load,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

    state_t                state;
    logic [DWELL_WL-1:0]   cnt;

    // Sweep settings captured at the start edge, so that later input changes
    // do not disturb a running sweep.
    logic [FREQ_WL-1:0]    sh_start;
    logic [FREQ_WL-1:0]    sh_stop;
    logic [FREQ_WL-1:0]    sh_step;
    logic [DWELL_WL-1:0]   sh_dwell;
    logic [1:0]            sh_mode;

    // This add is one bit wider than the frequency word, so it cannot wrap.
    // The result is clamped to hi.
    function automatic logic [FREQ_WL-1:0] sat_add(input logic [FREQ_WL-1:0] f,
                                                   input logic [FREQ_WL-1:0] s,
                                                   input logic [FREQ_WL-1:0] hi);
        logic [FREQ_WL:0] sum;
        sum = {1'b0, f} + {1'b0, s};
        if (sum > {1'b0, hi})
            return hi;
        return sum[FREQ_WL-1:0];
    endfunction

    // This subtract cannot underflow. It compares against lo+s at full
    // width and clamps the result to lo.
    function automatic logic [FREQ_WL-1:0] sat_sub(input logic [FREQ_WL-1:0] f,
                                                   input logic [FREQ_WL-1:0] s,
                                                   input logic [FREQ_WL-1:0] lo);
        logic [FREQ_WL:0] floor_sum;
        floor_sum = {1'b0, lo} + {1'b0, s};
        if ({1'b0, f} < floor_sum)
            return lo;
        return f - s;
    endfunction

    // Capture the sweep settings at the start edge. A step of zero is
    // stored as one so that the sweep always makes progress.
    always_ff @(posedge clk) begin
        if (state == IDLE && start && !stop) begin
            sh_start <= start_freq;
            sh_stop  <= stop_freq;
            sh_step  <= (step == '0) ? FREQ_WL'(1) : step;
            sh_dwell <= dwell;
            sh_mode  <= mode;
        end
    end

    // Sweep state machine. Every output is registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            freq  <= '0;
            load  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            load <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        freq  <= start_freq;
                        load  <= 1'b1;
                        cnt   <= dwell;
                        state <= UP;
                        busy  <= 1'b1;
                    end
                end
                UP: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (en) begin
                        if (cnt != '0) begin
                            cnt <= cnt - DWELL_WL'(1);
                        end else begin
                            cnt <= sh_dwell;
                            if (freq < sh_stop) begin
                                freq <= sat_add(freq, sh_step, sh_stop);
                                load <= 1'b1;
                            end else begin
                                case (sh_mode)
                                    2'b01: begin
                                        freq <= sh_start;
                                        load <= 1'b1;
                                    end
                                    2'b10: begin
                                        load <= 1'b1;
                                        // With no span to descend, the
                                        // triangle reduces to reloading start.
                                        if (sh_start >= sh_stop) begin
                                            freq <= sh_start;
                                        end else begin
                                            freq  <= sat_sub(freq, sh_step, sh_start);
                                            state <= DOWN;
                                        end
                                    end
                                    default: begin
                                        state <= IDLE;
                                        busy  <= 1'b0;
                                        done  <= 1'b1;
                                    end
                                endcase
                            end
                        end
                    end
                end
                DOWN: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (en) begin
                        if (cnt != '0) begin
                            cnt <= cnt - DWELL_WL'(1);
                        end else begin
                            cnt  <= sh_dwell;
                            load <= 1'b1;
                            if (freq > sh_start) begin
                                freq <= sat_sub(freq, sh_step, sh_start);
                            end else begin
                                freq  <= sat_add(freq, sh_step, sh_stop);
                                state <= UP;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sweep_ctrl.sv
// Testbench for sweep_ctrl. It has three parts: cycle tables, hand-written
// corner sequences, and random traffic. All parts are checked against a
// point-list reference model.
module tb_sweep_ctrl;

    localparam int FW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [FW-1:0] start_freq = '0;
    logic [FW-1:0] stop_freq = '0;
    logic [FW-1:0] step = '0;
    logic [DW-1:0] dwell = '0;
    logic [1:0]    mode = '0;
    logic [FW-1:0] freq;
    logic          load;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sweep_ctrl #(.FREQ_WL(FW), .DWELL_WL(DW)) dut (
        .clk(clk), .reset(reset), .en(en), .start(start), .stop(stop),
        .start_freq(start_freq), .stop_freq(stop_freq), .step(step),
        .dwell(dwell), .mode(mode), .freq(freq), .load(load),
        .busy(busy), .done(done)
    );

    // Reference model. At the start edge, the sweep becomes a list of
    // frequency points. The model then tracks the list index and the number
    // of enabled cycles spent on the current point.
    logic [FW-1:0] m_freq = '0;
    logic          m_load = 1'b0;
    logic          m_busy = 1'b0;
    logic          m_done = 1'b0;
    int            m_idx = 0;
    int            m_el = 0;
    int            m_sf = 0, m_st = 0, m_step = 1, m_dw = 0, m_mode = 0;
    int            up_q[$];
    int            per_q[$];

    task automatic build_lists();
        int f;
        up_q.delete();
        per_q.delete();
        f = m_sf;
        up_q.push_back(f);
        while (f < m_st) begin
            f = (f + m_step > m_st) ? m_st : f + m_step;
            up_q.push_back(f);
        end
        if (m_sf < m_st) begin
            for (int i = 1; i < up_q.size(); i++) per_q.push_back(up_q[i]);
            f = m_st;
            while (f > m_sf) begin
                f = (f - m_step < m_sf) ? m_sf : f - m_step;
                per_q.push_back(f);
            end
        end
    endtask

    function automatic int point(int idx);
        if (m_mode == 1) return up_q[idx % up_q.size()];
        if (m_mode == 2) begin
            if (m_sf >= m_st || idx == 0) return m_sf;
            return per_q[(idx - 1) % per_q.size()];
        end
        return up_q[idx];
    endfunction

    task automatic model_step();
        if (reset) begin
            m_freq = '0; m_load = 0; m_busy = 0; m_done = 0;
            m_idx = 0; m_el = 0;
            return;
        end
        m_load = 0;
        m_done = 0;
        if (!m_busy) begin
            if (start && !stop) begin
                m_sf = int'(start_freq); m_st = int'(stop_freq);
                m_step = (step == 0) ? 1 : int'(step);
                m_dw = int'(dwell);
                m_mode = (mode == 2'b11) ? 0 : int'(mode);
                build_lists();
                m_idx = 0; m_el = 0;
                m_freq = FW'(up_q[0]);
                m_load = 1; m_busy = 1;
            end
        end else if (stop) begin
            m_busy = 0;
        end else if (en) begin
            m_el++;
            if (m_el == m_dw + 1) begin
                m_el = 0;
                m_idx++;
                if (m_mode == 0 && m_idx >= up_q.size()) begin
                    m_done = 1; m_busy = 0;
                end else begin
                    m_freq = FW'(point(m_idx));
                    m_load = 1;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock and compare the DUT with the model. Inputs must be
    // set up before the call.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("model{freq,load,busy,done}", {freq, load, busy, done},
            {m_freq, m_load, m_busy, m_done});
    endtask

    typedef struct {
        logic rst, e, sta, sto;
        logic [FW-1:0] sf, st, stp;
        logic [DW-1:0] dw;
        logic [1:0] md;
        logic [FW-1:0] ef;
        logic el, eb, ed;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic rst, e, sta, sto, input int sf, st, stp, dw, md,
                       input int ef, input logic el, eb, ed);
        vec_t v;
        v.rst = rst; v.e = e; v.sta = sta; v.sto = sto;
        v.sf = FW'(sf); v.st = FW'(st); v.stp = FW'(stp); v.dw = DW'(dw); v.md = 2'(md);
        v.ef = FW'(ef); v.el = el; v.eb = eb; v.ed = ed;
        tbl.push_back(v);
    endtask

    initial begin
        int tri_f[5];
        int n;
        // Basic sweep 10 to 20 in steps of 5, each point held 3 cycles.
        add(1,1,0,0, 0,0,0,0,0,     0,0,0,0);
        add(0,1,1,0, 10,20,5,2,0,  10,1,1,0);
        add(0,1,0,0, 99,30,1,7,1,  10,0,1,0);
        add(0,1,1,0, 99,30,1,7,1,  10,0,1,0);
        add(0,1,0,0, 0,0,0,0,0,    15,1,1,0);
        add(0,1,0,0, 0,0,0,0,0,    15,0,1,0);
        add(0,1,0,0, 0,0,0,0,0,    15,0,1,0);
        add(0,1,0,0, 0,0,0,0,0,    20,1,1,0);
        add(0,1,0,0, 0,0,0,0,0,    20,0,1,0);
        add(0,1,0,0, 0,0,0,0,0,    20,0,1,0);
        add(0,1,0,0, 0,0,0,0,0,    20,0,0,1);
        add(0,1,0,0, 0,0,0,0,0,    20,0,0,0);
        add(0,1,1,1, 10,20,5,2,0,  20,0,0,0);
        // Clamped top point with a dwell of zero.
        add(0,1,1,0, 10,18,5,0,0,  10,1,1,0);
        add(0,1,0,0, 10,18,5,0,0,  15,1,1,0);
        add(0,1,0,0, 10,18,5,0,0,  18,1,1,0);
        add(0,1,0,0, 10,18,5,0,0,  18,0,0,1);

        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst; en = tbl[i].e; start = tbl[i].sta; stop = tbl[i].sto;
            start_freq = tbl[i].sf; stop_freq = tbl[i].st; step = tbl[i].stp;
            dwell = tbl[i].dw; mode = tbl[i].md;
            tick();
            chk($sformatf("vec%0d", i), {freq, load, busy, done},
                {tbl[i].ef, tbl[i].el, tbl[i].eb, tbl[i].ed});
        end

        // Triangle sweep: load pulses every cycle and busy never drops.
        start = 1; stop = 0; en = 1; start_freq = 0; stop_freq = 8; step = 4; dwell = 0; mode = 2'b10;
        tick();
        chk("tri_first", {freq, load}, {8'd0, 1'b1});
        start = 0;
        tri_f = '{4, 8, 4, 0, 4};
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("tri_pt%0d", k), {freq, load, busy}, {FW'(tri_f[k]), 1'b1, 1'b1});
        end
        stop = 1;
        tick();
        chk("tri_stop", {freq, load, busy, done}, {8'd4, 1'b0, 1'b0, 1'b0});
        stop = 0;

        // Dropping en stretches the point; stop then aborts with no done.
        start = 1; start_freq = 0; stop_freq = 100; step = 10; dwell = 3; mode = 2'b00;
        tick();
        start = 0;
        tick(); tick();
        en = 0;
        repeat (5) tick();
        chk("gate_hold", freq, 0);
        en = 1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!load && n < 20);
        chk("gate_len", 7 + n, 9);
        chk("gate_freq", freq, 10);
        stop = 1;
        tick();
        chk("abort", {freq, load, busy, done}, {8'd10, 1'b0, 1'b0, 1'b0});
        stop = 0;
        tick();
        chk("abort_nodone", done, 0);

        // Asynchronous reset in mid-sweep, then a sweep with step 0.
        start = 1; start_freq = 50; stop_freq = 60; step = 3; dwell = 1; mode = 2'b01;
        tick();
        start = 0;
        tick(); tick();
        #2;
        reset = 1;
        #1;
        chk("async_reset", {freq, busy, load}, {8'd0, 1'b0, 1'b0});
        tick();
        reset = 0;
        start = 1; start_freq = 3; stop_freq = 5; step = 0; dwell = 0; mode = 2'b00;
        tick();
        chk("step0_a", {freq, load}, {8'd3, 1'b1});
        start = 0;
        tick();
        chk("step0_b", {freq, load}, {8'd4, 1'b1});
        tick();
        chk("step0_c", {freq, load}, {8'd5, 1'b1});
        tick();
        chk("step0_done", {freq, busy, done}, {8'd5, 1'b0, 1'b1});

        // Sawtooth with start above stop: start is reloaded every dwell.
        start = 1; start_freq = 9; stop_freq = 4; step = 2; dwell = 1; mode = 2'b01;
        tick();
        chk("degen_first", {freq, load}, {8'd9, 1'b1});
        start = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("degen%0d", k), {freq, load, busy}, {8'd9, 1'(k % 2), 1'b1});
        end
        stop = 1;
        tick();
        stop = 0;

        // Random traffic checked against the model.
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            en    = ($urandom_range(0, 9) < 8);
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) == 0) begin
                start_freq = FW'($urandom_range(230, 255));
                stop_freq  = FW'($urandom_range(240, 255));
            end else begin
                start_freq = FW'($urandom_range(0, 40));
                stop_freq  = FW'($urandom_range(0, 60));
            end
            step  = FW'($urandom_range(0, 15));
            dwell = DW'($urandom_range(0, 3));
            mode  = 2'($urandom_range(0, 3));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
